// File: rtl/spi_slave_multi.sv
// SPI slave for multi-word frames. SCLK, SSEL and MOSI are oversampled on clk,
// and all framing, shifting and handshakes run on the rising edge of clk.
module spi_slave_multi #(
  parameter int WIDTH     = 32,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0,
  parameter int MAX_WORDS = 16,
  localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sclk,
  input  logic             spi_ssel,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic [CNT_W-1:0] word_count
);
  localparam int               BIT_W     = $clog2(WIDTH);
  localparam logic             SCLK_IDLE = (CPOL != 0);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] WC_MAX    = CNT_W'(MAX_WORDS);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic ssel_p0, ssel_p1, ssel_p2;
  logic mosi_p0, mosi_p1;
  logic primed, armed;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ssel_fall, ssel_rise, in_frame, do_sample, do_shift;
  logic start_nxt, end_nxt, load_now;
  logic [WIDTH-1:0] load_word, rx_shift, tx_shift;
  logic [BIT_W-1:0] bit_cnt;
  logic             word_vld_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == WC_MAX) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: edge-detect history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_p0 <= SCLK_IDLE;
      sclk_p1 <= SCLK_IDLE;
      sclk_p2 <= SCLK_IDLE;
      ssel_p0 <= 1'b1;
      ssel_p1 <= 1'b1;
      ssel_p2 <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      primed  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sclk_p0 <= spi_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      ssel_p0 <= spi_ssel;
      ssel_p1 <= ssel_p0;
      ssel_p2 <= ssel_p1;
      mosi_p0 <= spi_mosi;
      mosi_p1 <= mosi_p0;
      primed  <= 1'b1;
      // A frame may only start once SSEL has really been seen high, so a chip
      // select already low at reset release never produces a false start.
      if (primed && ssel_p0)
        armed <= 1'b1;
    end
  end

  assign sclk_rise   = sclk_p1 & ~sclk_p2;
  assign sclk_fall   = ~sclk_p1 & sclk_p2;
  assign lead_edge   = SCLK_IDLE ? sclk_fall : sclk_rise;
  assign trail_edge  = SCLK_IDLE ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign ssel_fall   = ~ssel_p1 & ssel_p2;
  assign ssel_rise   = ssel_p1 & ~ssel_p2;
  // SSEL high (including the cycle of its rising edge) masks any SCLK edge.
  assign in_frame    = (state == ACTIVE) & ~ssel_p1 & ~ssel_fall;
  assign do_sample   = in_frame & sample_edge;
  assign do_shift    = in_frame & shift_edge;

  assign load_word = tx_valid ? tx_data : '0;
  assign load_now  = start_nxt | (do_shift & (bit_cnt == '0) & (word_count != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ssel_fall && armed) begin
          state_nxt = ACTIVE;
          start_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssel_rise) begin
          state_nxt = IDLE;
          end_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: shift on SPI events; word_vld_p0 marks a completed receive word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      bit_cnt     <= '0;
      word_count  <= '0;
      word_vld_p0 <= 1'b0;
    end else begin
      frame_start <= start_nxt;
      frame_end   <= end_nxt;
      tx_ready    <= load_now & tx_valid;
      tx_underrun <= load_now & ~tx_valid;
      rx_valid    <= word_vld_p0;
      word_vld_p0 <= 1'b0;
      if (word_vld_p0) begin
        rx_data    <= rx_shift;
        word_count <= sat_inc(word_count);
      end
      if (start_nxt) begin
        bit_cnt    <= '0;
        word_count <= '0;
        rx_shift   <= '0;
        tx_shift   <= load_word;
      end else begin
        if (do_sample) begin
          rx_shift <= (LSB_FIRST != 0) ? {mosi_p1, rx_shift[WIDTH-1:1]}
                                       : {rx_shift[WIDTH-2:0], mosi_p1};
          bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT)
            word_vld_p0 <= 1'b1;
        end
        if (do_shift) begin
          if (bit_cnt == '0) begin
            if (word_count != '0)
              tx_shift <= load_word;
          end else begin
            tx_shift <= (LSB_FIRST != 0) ? {1'b0, tx_shift[WIDTH-1:1]}
                                         : {tx_shift[WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi_miso_oe = (state == ACTIVE);
  assign spi_miso    = (state == ACTIVE) &
                       ((LSB_FIRST != 0) ? tx_shift[0] : tx_shift[WIDTH-1]);

endmodule

// File: tb/tb_spi_slave_multi.sv
// Bench for spi_slave_multi: five configurations driven by a bit-level SPI master,
// checked against frame-level expectations computed from word counts and data tables.
module tb_spi_slave_multi;
  localparam int N = 5;
  localparam int H = 6;

  function automatic int cfg_w(input int i);    return (i == 0) ? 32 : (i == 4) ? 16 : 8; endfunction
  function automatic int cfg_cpol(input int i); return (i == 2 || i == 3 || i == 4) ? 1 : 0; endfunction
  function automatic int cfg_cpha(input int i); return (i == 1 || i == 3 || i == 4) ? 1 : 0; endfunction
  function automatic int cfg_lsb(input int i);  return (i >= 1 && i <= 3) ? 1 : 0; endfunction
  function automatic int cfg_mw(input int i);   return (i == 1) ? 3 : 16; endfunction

  logic clk;
  logic rst_n;
  logic [N-1:0] sclk, ssel, mosi, txv;
  logic [N-1:0] miso, oe, txr, txu, rxv, fs, fe;
  logic [63:0]  txd   [N];
  logic [63:0]  rxd_a [N];
  logic [7:0]   wc_a  [N];

  genvar g;
  for (g = 0; g < N; g++) begin : gi
    localparam int W   = cfg_w(g);
    localparam int CWD = $clog2(cfg_mw(g) + 1);
    logic [W-1:0]   rxd;
    logic [CWD-1:0] wc;
    spi_slave_multi #(
      .WIDTH(W), .CPOL(cfg_cpol(g)), .CPHA(cfg_cpha(g)),
      .LSB_FIRST(cfg_lsb(g)), .MAX_WORDS(cfg_mw(g))
    ) dut (
      .clk(clk), .rst_n(rst_n), .spi_sclk(sclk[g]), .spi_ssel(ssel[g]),
      .spi_mosi(mosi[g]), .spi_miso(miso[g]), .spi_miso_oe(oe[g]),
      .tx_data(txd[g][W-1:0]), .tx_valid(txv[g]), .tx_ready(txr[g]),
      .tx_underrun(txu[g]), .rx_data(rxd), .rx_valid(rxv[g]),
      .frame_start(fs[g]), .frame_end(fe[g]), .word_count(wc)
    );
    assign rxd_a[g] = 64'(rxd);
    assign wc_a[g]  = 8'(wc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;
  int cur;
  int c_fs[N], c_fe[N], c_rv[N], c_tr[N], c_tu[N];
  logic [63:0] rxq[$];
  logic [63:0] tx_w[8], mo_w[8], mi_w[8];
  bit          tx_v[8];
  logic [63:0] m_rx[N];
  bit          oe_ok;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fs[i])  c_fs[i]++;
      if (fe[i])  c_fe[i]++;
      if (rxv[i]) c_rv[i]++;
      if (txr[i]) c_tr[i]++;
      if (txu[i]) c_tu[i]++;
    end
    if (rxv[cur]) rxq.push_back(rxd_a[cur]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic fill_rand(input int w);
    for (int k = 0; k < 8; k++) begin
      tx_w[k] = {$urandom, $urandom} & mask_of(w);
      mo_w[k] = {$urandom, $urandom} & mask_of(w);
      tx_v[k] = bit'($urandom_range(0, 1));
    end
  endtask

  // Bit-level master; with coin set, SSEL rises together with the last sample edge.
  task automatic run_frame(input int nbits, input bit coin);
    int w, k, j, p;
    bit cpha, cpol, lsb, last;
    w    = cfg_w(cur);
    cpha = (cfg_cpha(cur) != 0);
    cpol = (cfg_cpol(cur) != 0);
    lsb  = (cfg_lsb(cur) != 0);
    for (int q = 0; q < 8; q++) mi_w[q] = '0;
    oe_ok = 1'b1;
    txd[cur] = tx_w[0];
    txv[cur] = tx_v[0];
    ssel[cur] = 1'b0;
    wt(8);
    for (int i = 0; i < nbits; i++) begin
      k = i / w;
      j = i % w;
      p = lsb ? j : w - 1 - j;
      last = (i == nbits - 1);
      if (!cpha) begin
        mosi[cur] = mo_w[k][p];
        wt(H);
        mi_w[k][p] = miso[cur];
        oe_ok &= oe[cur];
        sclk[cur] = ~sclk[cur];
        if (last && coin) ssel[cur] = 1'b1;
        wt(H);
        if (!last) begin
          if ((i + 1) % w == 0) begin
            txd[cur] = tx_w[k+1];
            txv[cur] = tx_v[k+1];
          end
          sclk[cur] = ~sclk[cur];
        end
      end else begin
        if (j == 0 && i > 0) begin
          txd[cur] = tx_w[k];
          txv[cur] = tx_v[k];
        end
        wt(H);
        sclk[cur] = ~sclk[cur];
        mosi[cur] = mo_w[k][p];
        wt(H);
        mi_w[k][p] = miso[cur];
        oe_ok &= oe[cur];
        sclk[cur] = ~sclk[cur];
        if (last && coin) ssel[cur] = 1'b1;
      end
    end
    if (!coin) begin
      wt(H);
      ssel[cur] = 1'b1;
    end
    wt(4);
    sclk[cur] = cpol;
    wt(10);
    txv[cur]  = 1'b0;
    mosi[cur] = 1'b0;
  endtask

  task automatic do_frame(input string tag, input int nbits, input bit coin);
    int w, mw, nfull, nload, nmiso, er, eu, q0;
    int b_fs, b_fe, b_rv, b_tr, b_tu;
    logic [63:0] exp_rx;
    w  = cfg_w(cur);
    mw = cfg_mw(cur);
    b_fs = c_fs[cur]; b_fe = c_fe[cur]; b_rv = c_rv[cur];
    b_tr = c_tr[cur]; b_tu = c_tu[cur];
    q0 = rxq.size();
    run_frame(nbits, coin);
    nfull = (nbits - int'(coin)) / w;
    nload = 1 + (nbits - 1) / w;
    nmiso = nbits / w;
    er = 0;
    eu = 0;
    for (int k = 0; k < nload; k++) if (tx_v[k]) er++; else eu++;
    chk($sformatf("%s.frame_start", tag), 64'(c_fs[cur] - b_fs), 64'd1);
    chk($sformatf("%s.frame_end", tag),   64'(c_fe[cur] - b_fe), 64'd1);
    chk($sformatf("%s.rx_valid", tag),    64'(c_rv[cur] - b_rv), 64'(nfull));
    chk($sformatf("%s.tx_ready", tag),    64'(c_tr[cur] - b_tr), 64'(er));
    chk($sformatf("%s.tx_underrun", tag), 64'(c_tu[cur] - b_tu), 64'(eu));
    for (int k = 0; k < nfull; k++)
      chk($sformatf("%s.rxword%0d", tag, k),
          (q0 + k < rxq.size()) ? rxq[q0+k] : 64'hx, mo_w[k]);
    exp_rx = (nfull > 0) ? mo_w[nfull-1] : m_rx[cur];
    m_rx[cur] = exp_rx;
    chk($sformatf("%s.rx_data", tag), rxd_a[cur], exp_rx);
    chk($sformatf("%s.word_count", tag), 64'(wc_a[cur]), 64'((nfull < mw) ? nfull : mw));
    for (int k = 0; k < nmiso; k++)
      chk($sformatf("%s.miso%0d", tag, k), mi_w[k], tx_v[k] ? tx_w[k] : 64'd0);
    chk($sformatf("%s.oe_active", tag), 64'(oe_ok), 64'd1);
    chk($sformatf("%s.idle_pins", tag), 64'({miso[cur], oe[cur]}), 64'd0);
  endtask

  initial begin
    int w, nb, b;
    bit cn;
    n_chk = 0;
    n_fail = 0;
    cur = 0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      sclk[i] = (cfg_cpol(i) != 0);
      ssel[i] = 1'b1;
      mosi[i] = 1'b0;
      txv[i]  = 1'b0;
      txd[i]  = '0;
      m_rx[i] = '0;
    end
    wt(5);
    chk("reset.pulses", 64'({fs, fe, rxv, txr, txu}), 64'd0);
    chk("reset.pins", 64'({miso, oe}), 64'd0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset.rx_data%0d", i), rxd_a[i], 64'd0);
      chk($sformatf("reset.word_count%0d", i), 64'(wc_a[i]), 64'd0);
    end
    rst_n = 1'b1;
    wt(10);
    chk("release.no_start", 64'(c_fs[0] + c_fs[1] + c_fs[2] + c_fs[3] + c_fs[4]), 64'd0);

    cur = 0;
    fill_rand(32);
    tx_w[0] = 64'hA5C3_0F01; tx_v[0] = 1'b1; mo_w[0] = 64'h1234_5678;
    do_frame("mode0_w32", 32, 1'b0);

    for (int c = 1; c <= 3; c++) begin
      cur = c;
      fill_rand(8);
      tx_w[0] = 64'h81; tx_v[0] = 1'b1; mo_w[0] = 64'h3C;
      do_frame($sformatf("lsb_mode%0d", c), 8, 1'b0);
      fill_rand(8);
      tx_v[0] = 1'b1;
      do_frame($sformatf("lsb_rand%0d", c), 8, 1'b0);
    end

    cur = 4;
    fill_rand(16);
    tx_v[0] = 1'b1; tx_v[1] = 1'b0; tx_v[2] = 1'b1;
    do_frame("three_word_underrun", 48, 1'b0);

    cur = 2;
    fill_rand(8);
    do_frame("partial5", 5, 1'b0);

    cur = 1;
    fill_rand(8);
    do_frame("coincide_cpha1", 8, 1'b1);
    cur = 0;
    fill_rand(32);
    do_frame("coincide_cpha0", 32, 1'b1);
    cur = 4;
    fill_rand(16);
    do_frame("coincide_second", 32, 1'b1);

    cur = 1;
    fill_rand(8);
    do_frame("saturate", 32, 1'b0);

    // Reset pulse in the middle of a mode-3 word.
    cur = 3;
    txd[3] = 64'h5A;
    txv[3] = 1'b1;
    ssel[3] = 1'b0;
    wt(8);
    for (int i = 0; i < 7; i++) begin
      wt(H);
      sclk[3] = ~sclk[3];
      mosi[3] = ~mosi[3];
    end
    rst_n = 1'b0;
    wt(1);
    chk("midreset.pulses", 64'({fs, fe, rxv, txr, txu}), 64'd0);
    chk("midreset.pins", 64'({miso, oe}), 64'd0);
    chk("midreset.rx_data", rxd_a[3], 64'd0);
    chk("midreset.word_count", 64'(wc_a[3]), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) m_rx[i] = '0;
    b = c_fs[3];
    wt(12);
    chk("midreset.no_start_low", 64'(c_fs[3] - b), 64'd0);
    sclk[3] = 1'b1;
    mosi[3] = 1'b0;
    wt(4);
    b = c_fe[3];
    ssel[3] = 1'b1;
    txv[3] = 1'b0;
    wt(10);
    chk("midreset.no_end", 64'(c_fe[3] - b), 64'd0);
    fill_rand(8);
    mo_w[0] = 64'hFF;
    do_frame("after_reset_ff", 8, 1'b0);

    for (int f = 0; f < 16; f++) begin
      cur = $urandom_range(0, N - 1);
      w   = cfg_w(cur);
      nb  = $urandom_range(1, 3 * w + w / 2);
      cn  = bit'($urandom_range(0, 1));
      fill_rand(w);
      do_frame($sformatf("rand%0d", f), nb, cn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
